// File: rtl/alu_unit.sv
// alu_unit: 16-bit multi-cycle ALU between the A-bus mux and the C-bus write-back.
// Latency: single-cycle ops give result/done one edge after acceptance; MUL/DIV run 16 bit-serial steps and finish 17 edges after acceptance.
// Backpressure: none; ALU_start is only honoured in IDLE and is dropped (not queued) while busy.
// Optional feature: define IAAA_ALU_DIV_EN to build the restoring divider (opcode 14) and drive REM_out.
module alu_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] A_BUS_in,
    input  logic [15:0] B_BUS_in,
    input  logic [3:0]  ALU_op,
    input  logic        ALU_start,
    output logic        ALU_busy,
    output logic        ALU_done,
    output logic        ALU_err,
    output logic [15:0] C_BUS_out,
    output logic [15:0] REM_out,
    output logic        Z_flag,
    output logic        N_flag,
    output logic        C_flag,
    output logic        V_flag
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_PSA  = 4'd11;
    localparam logic [3:0] OP_PSB  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
`ifdef IAAA_ALU_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'd14;
`endif

    localparam logic [4:0] LAST_STEP = 5'd15;

    // Architectural state
    logic [1:0]  r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [3:0]  r_op;
    logic [4:0]  r_cnt;
    // Iterative working pair: MUL keeps {partial high, multiplier/low product},
    // DIV keeps {partial remainder, dividend shifting into quotient}.
    logic [15:0] r_hi;
    logic [15:0] r_lo;

    // Output registers
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_c;
    logic        r_z;
    logic        r_n;
    logic        r_cf;
    logic        r_v;
`ifdef IAAA_ALU_DIV_EN
    logic [15:0] r_rem;
`endif

    // Single-cycle datapath outputs
    logic [16:0] w_sum17;
    logic [16:0] w_dif17;
    logic [16:0] w_inc17;
    logic [16:0] w_dec17;
    logic [15:0] w_res;
    logic        w_cf;
    logic        w_v;
    logic        w_err;

    // Iterative datapath
    logic        w_start_iter;
    logic [16:0] w_mul_sum17;
    logic [15:0] w_hi_next;
    logic [15:0] w_lo_next;
`ifdef IAAA_ALU_DIV_EN
    logic [16:0] w_div_shift17;
    logic        w_div_ge;
    logic [15:0] w_div_dif16;
`endif

    // Only these opcodes take the bit-serial path; everything else (including illegal) is two-cycle
`ifdef IAAA_ALU_DIV_EN
    assign w_start_iter = (ALU_op == OP_MUL) || (ALU_op == OP_DIV);
`else
    assign w_start_iter = (ALU_op == OP_MUL);
`endif

    // Single-cycle result and flag generation from latched operands
    always_comb begin
        w_sum17 = {1'b0, r_a} + {1'b0, r_b};
        w_dif17 = {1'b0, r_a} - {1'b0, r_b};
        w_inc17 = {1'b0, r_a} + 17'd1;
        w_dec17 = {1'b0, r_a} - 17'd1;
        w_res   = 16'h0000;
        w_cf    = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum17[15:0];
                w_cf  = w_sum17[16];
                w_v   = (r_a[15] == r_b[15]) && (w_sum17[15] != r_a[15]);
            end
            OP_SUB: begin
                w_res = w_dif17[15:0];
                w_cf  = w_dif17[16];
                w_v   = (r_a[15] != r_b[15]) && (w_dif17[15] != r_a[15]);
            end
            OP_INC: begin
                w_res = w_inc17[15:0];
                w_cf  = w_inc17[16];
                w_v   = (r_a == 16'h7FFF);
            end
            OP_DEC: begin
                w_res = w_dec17[15:0];
                w_cf  = w_dec17[16];
                w_v   = (r_a == 16'h8000);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_NOT: w_res = ~r_a;
            OP_SHL: begin
                w_res = {r_a[14:0], 1'b0};
                w_cf  = r_a[15];
            end
            OP_SHR: begin
                w_res = {1'b0, r_a[15:1]};
                w_cf  = r_a[0];
            end
            OP_PSA: w_res = r_a;
            OP_PSB: w_res = r_b;
            // Opcodes 0, 15 and (without the divider) 14 land here
            default: w_err = 1'b1;
        endcase
    end

    // One bit-serial step: shift-add for MUL, restoring subtract for DIV
    always_comb begin
        w_mul_sum17 = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 17'd0);
        w_hi_next   = w_mul_sum17[16:1];
        w_lo_next   = {w_mul_sum17[0], r_lo[15:1]};
`ifdef IAAA_ALU_DIV_EN
        // Partial remainder never exceeds 16 bits, so the low 16 bits of the
        // modular difference are exact whenever the subtract is kept.
        w_div_shift17 = {r_hi, r_lo[15]};
        w_div_ge      = (w_div_shift17 >= {1'b0, r_b});
        w_div_dif16   = w_div_shift17[15:0] - r_b;
        if (r_op == OP_DIV) begin
            w_hi_next = w_div_ge ? w_div_dif16 : w_div_shift17[15:0];
            w_lo_next = {r_lo[14:0], w_div_ge};
        end
`endif
    end

    // Control FSM, iterative datapath and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_op    <= 4'h0;
            r_cnt   <= 5'd0;
            r_hi    <= 16'h0000;
            r_lo    <= 16'h0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_c     <= 16'h0000;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_cf    <= 1'b0;
            r_v     <= 1'b0;
`ifdef IAAA_ALU_DIV_EN
            r_rem   <= 16'h0000;
`endif
        end else begin
            // done/err are single-cycle pulses
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ALU_start) begin
                        r_a    <= A_BUS_in;
                        r_b    <= B_BUS_in;
                        r_op   <= ALU_op;
                        r_busy <= 1'b1;
                        r_cnt  <= 5'd0;
                        r_hi   <= 16'h0000;
`ifdef IAAA_ALU_DIV_EN
                        r_lo   <= (ALU_op == OP_DIV) ? A_BUS_in : B_BUS_in;
`else
                        r_lo   <= B_BUS_in;
`endif
                        r_state <= w_start_iter ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_c     <= w_res;
                    r_z     <= (w_res == 16'h0000);
                    r_n     <= w_res[15];
                    r_cf    <= w_cf;
                    r_v     <= w_v;
                    r_err   <= w_err;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
`ifdef IAAA_ALU_DIV_EN
                    r_rem   <= 16'h0000;
`endif
                    r_state <= S_IDLE;
                end
                S_ITER: begin
                    r_hi <= w_hi_next;
                    r_lo <= w_lo_next;
                    if (r_cnt == LAST_STEP) begin
                        r_cnt   <= 5'd0;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIN: begin
                    // Both MUL and DIV deliver the low/quotient word on the C bus
                    r_c    <= r_lo;
                    r_z    <= (r_lo == 16'h0000);
                    r_n    <= r_lo[15];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
`ifdef IAAA_ALU_DIV_EN
                    if (r_op == OP_DIV) begin
                        r_rem <= r_hi;
                        r_cf  <= 1'b0;
                        r_v   <= (r_b == 16'h0000);
                    end else begin
                        r_rem <= 16'h0000;
                        r_cf  <= (r_hi != 16'h0000);
                        r_v   <= 1'b0;
                    end
`else
                    r_cf   <= (r_hi != 16'h0000);
                    r_v    <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ALU_busy  = r_busy;
    assign ALU_done  = r_done;
    assign ALU_err   = r_err;
    assign C_BUS_out = r_c;
    assign Z_flag    = r_z;
    assign N_flag    = r_n;
    assign C_flag    = r_cf;
    assign V_flag    = r_v;
`ifdef IAAA_ALU_DIV_EN
    assign REM_out   = r_rem;
`else
    assign REM_out   = 16'h0000;
`endif

endmodule
